// File: rtl/lfsr_param_if.sv
// Seed-load handshake and status bundle for lfsr_param.
// master drives the advance request and seed offer; slave is the generator.
interface lfsr_param_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
);
  logic             en;
  logic [WIDTH-1:0] seed;
  logic             seed_valid;
  logic             seed_ready;
  logic [WIDTH-1:0] lfsr_out;
  logic             out_valid;
  logic             seed_err;
  logic             lockup;
  logic             period_done;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output en, seed, seed_valid,
    input  seed_ready, lfsr_out, out_valid, seed_err, lockup, period_done, step_cnt
  );

  modport slave (
    input  en, seed, seed_valid,
    output seed_ready, lfsr_out, out_valid, seed_err, lockup, period_done, step_cnt
  );
endinterface

// File: rtl/lfsr_param.sv
// Parametrised Galois/Fibonacci LFSR with seed handshake, multi-step advance and lock-up recovery.
// Optional macro LFSR_PERIOD_CHECK_EN adds the seed reference, step counter and period_done.
module lfsr_param #(
  parameter int               WIDTH         = 16,
  parameter logic [WIDTH-1:0] TAPS          = 16'hB400,
  parameter int               GALOIS        = 1,
  parameter int               STEPS_PER_CLK = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W         = 32
) (
  input  logic          clk,
  input  logic          resetn,
  lfsr_param_if.slave   bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             out_valid_q, out_valid_d;
  logic             seed_ready_q, seed_ready_d;
  logic             seed_err_q, seed_err_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] adv_val;
  logic [WIDTH-1:0] load_value;
  logic             seed_fire;
  logic             do_load, do_adv, do_lock;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    if (GALOIS != 0) n = (s >> 1) ^ (s[0] ? TAPS : '0);
    else             n = {s[WIDTH-2:0], ^(s & TAPS)};
    return n;
  endfunction

  // All steps of one cycle are chained; a zero anywhere stays zero, so only the end needs checking.
  always_comb begin
    adv_val = lfsr_q;
    for (int i = 0; i < STEPS_PER_CLK; i++) adv_val = lfsr_step(adv_val);
  end

  assign seed_fire = bus.seed_valid & seed_ready_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    out_valid_d  = (state_q == ST_RUN);
    seed_ready_d = 1'b1;
    seed_err_d   = 1'b0;
    lockup_d     = 1'b0;
    do_load      = 1'b0;
    do_adv       = 1'b0;
    do_lock      = 1'b0;
    load_value   = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;

    if (seed_fire) begin
      lfsr_d      = load_value;
      state_d     = ST_RUN;
      out_valid_d = 1'b1;
      seed_err_d  = (bus.seed == '0);
      do_load     = 1'b1;
    end else if (state_q == ST_IDLE) begin
      if (bus.en) begin
        load_value  = DEFAULT_SEED;
        lfsr_d      = DEFAULT_SEED;
        state_d     = ST_RUN;
        out_valid_d = 1'b1;
        do_load     = 1'b1;
      end
    end else if (bus.en) begin
      if (adv_val == '0) begin
        lfsr_d   = DEFAULT_SEED;
        lockup_d = 1'b1;
        do_lock  = 1'b1;
      end else begin
        lfsr_d = adv_val;
        do_adv = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= DEFAULT_SEED;
      out_valid_q  <= 1'b0;
      seed_ready_q <= 1'b1;
      seed_err_q   <= 1'b0;
      lockup_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      seed_ready_q <= seed_ready_d;
      seed_err_q   <= seed_err_d;
      lockup_q     <= lockup_d;
    end
  end

  assign bus.lfsr_out   = lfsr_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.seed_ready = seed_ready_q;
  assign bus.seed_err   = seed_err_q;
  assign bus.lockup     = lockup_q;

`ifdef LFSR_PERIOD_CHECK_EN
  logic [WIDTH-1:0] seed_ref_q, seed_ref_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             period_done_q, period_done_d;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    cnt_sum       = {1'b0, step_cnt_q} + (CNT_W+1)'(STEPS_PER_CLK);
    seed_ref_d    = seed_ref_q;
    step_cnt_d    = step_cnt_q;
    period_done_d = 1'b0;
    if (do_load) begin
      seed_ref_d = load_value;
      step_cnt_d = '0;
    end else if (do_lock) begin
      seed_ref_d = DEFAULT_SEED;
      step_cnt_d = '0;
    end else if (do_adv) begin
      // Counter saturates rather than wrapping; it is not cleared when the period completes.
      step_cnt_d    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      period_done_d = (adv_val == seed_ref_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seed_ref_q    <= DEFAULT_SEED;
      step_cnt_q    <= '0;
      period_done_q <= 1'b0;
    end else begin
      seed_ref_q    <= seed_ref_d;
      step_cnt_q    <= step_cnt_d;
      period_done_q <= period_done_d;
    end
  end

  assign bus.step_cnt    = step_cnt_q;
  assign bus.period_done = period_done_q;
`else
  logic unused_period;
  assign unused_period   = ^{load_value, do_load, do_adv, do_lock};
  assign bus.step_cnt    = '0;
  assign bus.period_done = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_param.sv
// Directed bench for lfsr_param: four configurations share one clock and reset.
// Period-related expectations follow LFSR_PERIOD_CHECK_EN.
module tb_lfsr_param;

  logic clk;
  logic resetn;
  int   passed;
  int   total;

`ifdef LFSR_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  lfsr_param_if #(.WIDTH(16), .CNT_W(32)) i_g   ();
  lfsr_param_if #(.WIDTH(16), .CNT_W(32)) i_fib ();
  lfsr_param_if #(.WIDTH(16), .CNT_W(32)) i_s2  ();
  lfsr_param_if #(.WIDTH(16), .CNT_W(32)) i_z   ();

  lfsr_param u_gal (.clk(clk), .resetn(resetn), .bus(i_g));
  lfsr_param #(.GALOIS(0))        u_fib (.clk(clk), .resetn(resetn), .bus(i_fib));
  lfsr_param #(.STEPS_PER_CLK(2)) u_s2  (.clk(clk), .resetn(resetn), .bus(i_s2));
  lfsr_param #(.TAPS(16'h0000))   u_z   (.clk(clk), .resetn(resetn), .bus(i_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ecnt(input int n);
    return PCHK ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {i_g.en, i_g.seed_valid, i_fib.en, i_fib.seed_valid} = '0;
    {i_s2.en, i_s2.seed_valid, i_z.en, i_z.seed_valid} = '0;
    i_g.seed = '0; i_fib.seed = '0; i_s2.seed = '0; i_z.seed = '0;
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    repeat (5) tick();
    total++; if (i_g.lfsr_out !== 16'h0001) $display("FAIL reset_lfsr: got %h want 0001", i_g.lfsr_out); else passed++;
    total++; if (i_g.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", i_g.out_valid); else passed++;
    total++; if (i_g.step_cnt !== 32'd0) $display("FAIL reset_step_cnt: got %0d want 0", i_g.step_cnt); else passed++;
    total++; if (i_g.seed_ready !== 1'b1) $display("FAIL reset_seed_ready: got %b want 1", i_g.seed_ready); else passed++;
    total++; if ({i_g.seed_err, i_g.lockup, i_g.period_done} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {i_g.seed_err, i_g.lockup, i_g.period_done}); else passed++;
  endtask

  task automatic test_galois();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'hB400; exp_seq[1] = 16'h5A00; exp_seq[2] = 16'h2D00;
    i_g.seed = 16'h0001; i_g.seed_valid = 1'b1;
    tick();
    i_g.seed_valid = 1'b0;
    total++; if (i_g.lfsr_out !== 16'h0001) $display("FAIL galois_load: got %h want 0001", i_g.lfsr_out); else passed++;
    total++; if (i_g.out_valid !== 1'b1) $display("FAIL galois_out_valid: got %b want 1", i_g.out_valid); else passed++;
    i_g.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (i_g.lfsr_out !== exp_seq[i]) $display("FAIL galois_step%0d: got %h want %h", i, i_g.lfsr_out, exp_seq[i]); else passed++;
    end
    i_g.en = 1'b0;
    total++; if (i_g.step_cnt !== ecnt(3)) $display("FAIL galois_step_cnt: got %0d want %0d", i_g.step_cnt, ecnt(3)); else passed++;
    tick();
    total++; if (i_g.lfsr_out !== 16'h2D00) $display("FAIL galois_hold: got %h want 2d00", i_g.lfsr_out); else passed++;
  endtask

  task automatic test_fibonacci();
    i_fib.seed = 16'h0002; i_fib.seed_valid = 1'b1;
    tick();
    i_fib.seed_valid = 1'b0; i_fib.en = 1'b1;
    tick();
    i_fib.en = 1'b0;
    total++; if (i_fib.lfsr_out !== 16'h0004) $display("FAIL fib_step: got %h want 0004", i_fib.lfsr_out); else passed++;
  endtask

  task automatic test_multistep();
    i_s2.seed = 16'h0001; i_s2.seed_valid = 1'b1;
    tick();
    i_s2.seed_valid = 1'b0; i_s2.en = 1'b1;
    tick();
    i_s2.en = 1'b0;
    total++; if (i_s2.lfsr_out !== 16'h5A00) $display("FAIL steps2_value: got %h want 5a00", i_s2.lfsr_out); else passed++;
    total++; if (i_s2.step_cnt !== ecnt(2)) $display("FAIL steps2_cnt: got %0d want %0d", i_s2.step_cnt, ecnt(2)); else passed++;
  endtask

  task automatic test_zero_seed();
    i_g.seed = 16'h0000; i_g.seed_valid = 1'b1;
    tick();
    i_g.seed_valid = 1'b0;
    total++; if (i_g.lfsr_out !== 16'h0001) $display("FAIL zero_seed_value: got %h want 0001", i_g.lfsr_out); else passed++;
    total++; if (i_g.seed_err !== 1'b1) $display("FAIL zero_seed_err: got %b want 1", i_g.seed_err); else passed++;
    total++; if (i_g.step_cnt !== 32'd0) $display("FAIL zero_seed_cnt: got %0d want 0", i_g.step_cnt); else passed++;
    tick();
    total++; if (i_g.seed_err !== 1'b0) $display("FAIL zero_seed_pulse: got %b want 0", i_g.seed_err); else passed++;
  endtask

  task automatic test_load_priority();
    i_g.en = 1'b1;
    tick();
    i_g.seed = 16'h1234; i_g.seed_valid = 1'b1;
    tick();
    i_g.seed_valid = 1'b0; i_g.en = 1'b0;
    total++; if (i_g.lfsr_out !== 16'h1234) $display("FAIL prio_value: got %h want 1234", i_g.lfsr_out); else passed++;
    total++; if (i_g.step_cnt !== 32'd0) $display("FAIL prio_cnt: got %0d want 0", i_g.step_cnt); else passed++;
    total++; if (i_g.seed_err !== 1'b0) $display("FAIL prio_seed_err: got %b want 0", i_g.seed_err); else passed++;
  endtask

  task automatic test_period();
    int pulses;
    int at_step;
    pulses = 0; at_step = 0;
    i_g.seed = 16'hACE1; i_g.seed_valid = 1'b1;
    tick();
    i_g.seed_valid = 1'b0; i_g.en = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (i_g.period_done === 1'b1) begin
        pulses++;
        at_step = i;
      end
    end
    i_g.en = 1'b0;
    total++; if (i_g.lfsr_out !== 16'hACE1) $display("FAIL period_value: got %h want ace1", i_g.lfsr_out); else passed++;
    total++; if (i_g.step_cnt !== ecnt(65535)) $display("FAIL period_cnt: got %0d want %0d", i_g.step_cnt, ecnt(65535)); else passed++;
    total++; if (pulses != (PCHK ? 1 : 0)) $display("FAIL period_pulses: got %0d want %0d", pulses, PCHK ? 1 : 0); else passed++;
    total++; if (at_step != (PCHK ? 65535 : 0)) $display("FAIL period_at_step: got %0d want %0d", at_step, PCHK ? 65535 : 0); else passed++;
    tick();
    total++; if (i_g.period_done !== 1'b0) $display("FAIL period_pulse_end: got %b want 0", i_g.period_done); else passed++;
  endtask

  task automatic test_lockup();
    i_z.seed = 16'h0001; i_z.seed_valid = 1'b1;
    tick();
    i_z.seed_valid = 1'b0; i_z.en = 1'b1;
    tick();
    i_z.en = 1'b0;
    total++; if (i_z.lfsr_out !== 16'h0001) $display("FAIL lockup_value: got %h want 0001", i_z.lfsr_out); else passed++;
    total++; if (i_z.lockup !== 1'b1) $display("FAIL lockup_pulse: got %b want 1", i_z.lockup); else passed++;
    total++; if (i_z.step_cnt !== 32'd0) $display("FAIL lockup_cnt: got %0d want 0", i_z.step_cnt); else passed++;
    tick();
    total++; if (i_z.lockup !== 1'b0) $display("FAIL lockup_pulse_end: got %b want 0", i_z.lockup); else passed++;
    i_z.seed = 16'h0001; i_z.seed_valid = 1'b1; i_z.en = 1'b1;
    tick();
    i_z.seed_valid = 1'b0; i_z.en = 1'b0;
    total++; if (i_z.lockup !== 1'b0) $display("FAIL lockup_vs_load: got %b want 0", i_z.lockup); else passed++;
    total++; if (i_z.lfsr_out !== 16'h0001) $display("FAIL lockup_vs_load_value: got %h want 0001", i_z.lfsr_out); else passed++;
  endtask

  task automatic test_async_reset();
    i_g.en = 1'b1;
    repeat (3) tick();
    #3;
    resetn = 1'b0;
    #1;
    total++; if (i_g.lfsr_out !== 16'h0001) $display("FAIL areset_lfsr: got %h want 0001", i_g.lfsr_out); else passed++;
    total++; if (i_g.out_valid !== 1'b0) $display("FAIL areset_out_valid: got %b want 0", i_g.out_valid); else passed++;
    total++; if (i_g.step_cnt !== 32'd0) $display("FAIL areset_cnt: got %0d want 0", i_g.step_cnt); else passed++;
    i_g.en = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    total++; if (i_g.out_valid !== 1'b0) $display("FAIL idle_hold_valid: got %b want 0", i_g.out_valid); else passed++;
    i_g.en = 1'b1;
    tick();
    total++; if ({i_g.out_valid, i_g.lfsr_out} !== {1'b1, 16'h0001})
      $display("FAIL idle_en_start: got %b/%h want 1/0001", i_g.out_valid, i_g.lfsr_out); else passed++;
    tick();
    i_g.en = 1'b0;
    total++; if (i_g.lfsr_out !== 16'hB400) $display("FAIL idle_en_advance: got %h want b400", i_g.lfsr_out); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    resetn = 1'b0;
    test_reset();
    test_galois();
    test_fibonacci();
    test_multistep();
    test_zero_seed();
    test_load_priority();
    test_lockup();
    test_period();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lfsr_param.md
Name: lfsr_param

Overview:
Parametrised pseudo-random sequence generator, the successor to the fixed 16-bit lfsr1.
- Adds configurable width, tap polynomial and Galois/Fibonacci mode.
- Adds 1..4 steps per clock, an advance enable, a valid/ready seed-load handshake, and zero-state lock-up protection.
- Feeds test-pattern and stimulus paths in the divider datapath; output is registered.

Parameters:
WIDTH, 16, register width (4..32)
TAPS, 16'hB400, feedback mask, WIDTH bits (bit i set = tap on stage i)
GALOIS, 1, 1 = Galois right-shift; 0 = Fibonacci left-shift
STEPS_PER_CLK, 1, LFSR advances per enabled cycle (1..4)
DEFAULT_SEED, 1, reset/recovery value; must be non-zero
CNT_W, 32, width of step counter

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
en  in  1  advance request
seed  in  WIDTH  seed value
seed_valid  in  1  seed offered
seed_ready  out  1  seed accepted when high with seed_valid
lfsr_out  out  WIDTH  current register state
out_valid  out  1  lfsr_out is a RUN-state value
seed_err  out  1  one-cycle pulse: all-zero seed replaced
lockup  out  1  one-cycle pulse: zero state detected and recovered
period_done  out  1  one-cycle pulse: sequence returned to loaded seed
step_cnt  out  CNT_W  steps since last load

Behaviour:
- Reset: one clock `clk`, reset `resetn`, asynchronous, active-low.
  - Reset values: state IDLE, lfsr_out=DEFAULT_SEED, out_valid=0, seed_ready=1, seed_err=0, lockup=0, period_done=0, step_cnt=0, seed reference=DEFAULT_SEED.
  - Reset asserted mid-run aborts immediately to these values.
- Single step:
  - Galois: next = (s>>1) ^ (s[0] ? TAPS : 0).
  - Fibonacci: next = {s[WIDTH-2:0], ^(s & TAPS)}.
  - STEPS_PER_CLK steps are chained combinationally within one cycle.
- States: IDLE, RUN.
  - IDLE: register holds, out_valid=0.
    - IDLE->RUN on accepted seed: load seed.
    - IDLE->RUN on en=1 with no seed: load DEFAULT_SEED, no advance that cycle.
  - RUN: en=1 advances STEPS_PER_CLK steps per clock; en=0 holds; out_valid=1.
  - No transition back to IDLE except reset.
- Seed handshake:
  - seed_ready is 1 in every state; transfer when seed_valid & seed_ready.
  - Loaded value appears on lfsr_out after the same rising edge (latency 1).
  - Load has priority over en in the same cycle (no advance that cycle).
  - Load clears step_cnt to 0 and stores the seed reference.
- Zero seed: an accepted all-zero seed loads DEFAULT_SEED; seed_err pulses on the following cycle.
- Lock-up:
  - If a computed next state is all-zero (non-primitive TAPS), the register loads DEFAULT_SEED instead.
  - lockup pulses one cycle.
  - step_cnt clears; seed reference becomes DEFAULT_SEED.
- step_cnt:
  - Increments by STEPS_PER_CLK per advance; saturates at all-ones.
  - For STEPS_PER_CLK > 1, the count includes all steps of the cycle.
- period_done:
  - Pulses in the cycle after an advance whose final value equals the seed reference.
  - step_cnt shows the period in that cycle; step_cnt does not reset on wrap.
  - For STEPS_PER_CLK > 1, only the final value of the cycle is compared; intermediate matches are not flagged.
- Simultaneous load and lock-up: load wins; lockup not asserted.

Optional Feature:
LFSR_PERIOD_CHECK_EN:
- Defined: seed reference register, step_cnt and period_done are implemented as above.
- Undefined: reference register and counter are omitted; step_cnt tied to 0; period_done tied to 0. All other behaviour is unchanged.

Test Plan:
- Reset, then hold en=0, 5 cycles -> lfsr_out=0x0001, out_valid=0, step_cnt=0.
- Galois defaults; load seed 0x0001, then en=1 for 3 cycles -> lfsr_out 0x0001, 0xB400, 0x5A00, 0x2D00; out_valid=1 from load.
- GALOIS=0; load seed 0x0002, en=1 one cycle -> lfsr_out=0x0004. With STEPS_PER_CLK=2, GALOIS=1, seed 0x0001, one enabled cycle -> 0x5A00, step_cnt=2.
- Load seed 0x0000 -> lfsr_out=0x0001, seed_err single pulse. seed_valid and en high together with seed 0x1234 -> lfsr_out=0x1234, step_cnt=0.
- LFSR_PERIOD_CHECK_EN defined; seed 0xACE1, en=1 for 65535 cycles -> period_done single pulse, step_cnt=65535, lfsr_out=0xACE1. Macro undefined -> period_done never asserts.
- TAPS=16'h0000 (non-primitive), seed 0x0001, en=1 -> next cycle lfsr_out=0x0001, lockup pulse. Assert resetn low mid-run -> outputs return to reset values without a clock edge.
